div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU. Sits beside alu_core:
//  consumes dividend/divisor/div_start from the ALU and returns a one-cycle div_res_ready
//  pulse with div_result. The ALU holds div_start high, and holds alu_busy, until that pulse.
// PARAMETERS
//  WIDTH  `CPU_WIDTH (32)  operand/result width; the iteration count equals WIDTH
// PORTS
//  clk              in   1      single clock, rising edge
//  rst_n            in   1      asynchronous, active-low reset
//  div_start_i      in   1      request from alu_core (level, held until ready)
//  div_op_i         in   2      `DIV_OP_DIV=00, `DIV_OP_DIVU=01, `DIV_OP_REM=10, `DIV_OP_REMU=11
//  dividend_i       in   WIDTH  dividend (rs1)
//  divisor_i        in   WIDTH  divisor (rs2)
//  flush_i          in   1      pipeline flush; aborts any operation
//  div_res_ready_o  out  1      one-cycle pulse; div_result_o valid in this cycle
//  div_result_o     out  WIDTH  quotient or remainder, per latched op
//  div_busy_o       out  1      high whenever state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; all outputs 0; counter and datapath registers 0.
//  FSM: IDLE -> CALC -> DONE -> IDLE.
//   IDLE: if div_start_i & !flush_i, latch op, |dividend|, |divisor| and both sign flags.
//         Signed ops only take magnitudes and set sign flags.
//         divisor==0 or (signed & dividend==0x80000000 & divisor==0xFFFFFFFF): load special
//         result, go to DONE. Otherwise rem=0, quo=|dividend|, cnt=0, go to CALC.
//   CALC: each cycle {rem,quo} <<= 1; if rem >= |divisor|: rem -= |divisor|, quo[0]=1.
//         At cnt==WIDTH-1, apply sign fix and register result, then go to DONE.
//   DONE: div_res_ready_o=1 for exactly this cycle, then go to IDLE. div_start_i is ignored here.
//  Latency (start first seen in cycle 0): normal ops give ready in cycle WIDTH+1 (33);
//   special cases give ready in cycle 1. Back-to-back: a new start is accepted in the IDLE
//   cycle after DONE.
//  Sign fix: quotient is negated when the operand signs differ (signed ops only).
//   Remainder takes the dividend sign. Unsigned ops use raw values.
//  Special results:
//   - divide by zero: quotient = all ones; remainder = dividend.
//   - signed overflow: quotient = 0x80000000; remainder = 0.
//  Operands are latched. Input changes during CALC/DONE are ignored.
//  div_result_o holds its last value outside the ready pulse.
//  flush_i: from any state, go to IDLE on the next edge; no ready pulse is issued.
//   flush_i wins over a simultaneous div_start_i. A flush in DONE still shows ready in
//   that same cycle, because ready is a Moore output of state.
//  div_start_i dropping mid-CALC does not abort; only flush_i aborts.
//  Counter width: $clog2(WIDTH); it must not wrap before the DONE transition.
// STRUCTURE
//  rooth_defines.v: `CPU_WIDTH and the `DIV_OP_* codes. Local parameters: state encodings
//   S_IDLE/S_CALC/S_DONE.
//  Single module; no sub-module. The datapath is one WIDTH+1 bit subtractor plus shift
//   registers rem/quo.
// TESTING
//  1 DIVU 100/7 -> ready in cycle 33 only, result 14. REMU 100/7 -> 2. busy high cycles 1..33.
//  2 DIV 0xFFFFFF9C/7 -> 0xFFFFFFF2. REM 0xFFFFFF9C/7 -> 0xFFFFFFFE.
//    REM 7/0xFFFFFFFE -> 1.
//  3 DIV 5/0 -> 0xFFFFFFFF. DIVU 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5. Each gives ready in cycle 1.
//  4 DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0. Ready in cycle 1.
//    DIVU same operands -> 0x00000000 via the normal 33-cycle path.
//  5 flush_i in cycle 10 of CALC -> busy=0 next cycle, no ready pulse;
//    a following DIVU 9/3 -> 3 in cycle 33.
//  6 rst_n low in cycle 15 of CALC -> ready, busy and result all 0 immediately.
//    Two back-to-back DIVU ops -> two ready pulses, 34 cycles apart.

Source files
------------

// File: rtl/div_unit_pkg.sv
// ---------------------------------------------------------------------------
// div_unit_pkg : shared width, operation codes and FSM states for div_unit
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package div_unit_pkg;

  localparam int CPU_WIDTH = 32;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

endpackage

`default_nettype wire

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit : multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_start_i,
  input  logic [1:0]       div_op_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             flush_i,
  output logic             div_res_ready_o,
  output logic [WIDTH-1:0] div_result_o,
  output logic             div_busy_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state, state_nxt;
  logic [1:0]       op;
  logic [WIDTH-1:0] rem, quo, dvs, result;
  logic             neg_q, neg_r;
  logic [CNT_W-1:0] cnt;

  // Operand decode in IDLE
  logic             is_signed, a_neg, b_neg, div_zero, ovf, special, start_ok;
  logic [WIDTH-1:0] a_mag, b_mag, special_res;

  assign is_signed = ~div_op_i[0];
  assign a_neg     = is_signed & dividend_i[WIDTH-1];
  assign b_neg     = is_signed & divisor_i[WIDTH-1];
  assign a_mag     = a_neg ? -dividend_i : dividend_i;
  assign b_mag     = b_neg ? -divisor_i  : divisor_i;
  assign div_zero  = (divisor_i == '0);
  assign ovf       = is_signed & (dividend_i == MIN_NEG) & (divisor_i == '1);
  assign special   = div_zero | ovf;
  assign start_ok  = (state == S_IDLE) & div_start_i & ~flush_i;

  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = div_op_i[1] ? dividend_i : '1;
    else
      special_res = div_op_i[1] ? '0 : MIN_NEG;
  end

  // One restoring step: the WIDTH+1 bit difference's MSB is the borrow
  logic [WIDTH:0]   rem_sh, diff;
  logic [WIDTH-1:0] rem_nxt, quo_nxt, q_fix, r_fix;
  logic             last;

  assign rem_sh  = {rem, quo[WIDTH-1]};
  assign diff    = rem_sh - {1'b0, dvs};
  assign rem_nxt = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], ~diff[WIDTH]};
  assign last    = (cnt == CNT_W'(WIDTH-1));
  assign q_fix   = neg_q ? -quo_nxt : quo_nxt;
  assign r_fix   = neg_r ? -rem_nxt : rem_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = special ? S_DONE : S_CALC;
      S_CALC:  if (last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush_i) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op     <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else if (start_ok) begin
      op    <= div_op_i;
      dvs   <= b_mag;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      rem   <= '0;
      quo   <= a_mag;
      cnt   <= '0;
      if (special) result <= special_res;
    end else if ((state == S_CALC) && !flush_i) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
      cnt <= cnt + 1'b1;
      if (last) result <= op[1] ? r_fix : q_fix;
    end
  end

  assign div_res_ready_o = (state == S_DONE);
  assign div_busy_o      = (state != S_IDLE);
  assign div_result_o    = result;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit : directed and random checks of div_unit against an arithmetic model
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        div_start;
  logic [1:0]  div_op;
  logic [31:0] dividend, divisor;
  logic        flush;
  logic        div_res_ready;
  logic [31:0] div_result;
  logic        div_busy;

  int errors = 0;
  int checks = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .div_start_i     (div_start),
    .div_op_i        (div_op),
    .dividend_i      (dividend),
    .divisor_i       (divisor),
    .flush_i         (flush),
    .div_res_ready_o (div_res_ready),
    .div_result_o    (div_result),
    .div_busy_o      (div_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, sr;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    sa = int'(a);
    sb = int'(b);
    case (op)
      2'b00:   sr = sa / sb;
      2'b10:   sr = sa % sb;
      2'b01:   return a / b;
      default: return a % b;
    endcase
    return 32'(sr);
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    int          k;
    logic        seen, busy_ok;
    logic [31:0] res;
    k = 0; seen = 1'b0; busy_ok = 1'b1; res = 'x;
    div_op = op; dividend = a; divisor = b; div_start = 1'b1;
    while (!seen && k < 100) begin
      @(negedge clk);
      k++;
      if (div_busy !== 1'b1) busy_ok = 1'b0;
      if (div_res_ready === 1'b1) begin
        seen = 1'b1;
        res  = div_result;
      end
    end
    div_start = 1'b0;
    dividend = $urandom; divisor = $urandom;
    check({tag, "_lat"}, 32'(k), is_special(op, a, b) ? 32'd1 : 32'd33);
    check({tag, "_res"}, res, ref_res(op, a, b));
    check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, div_res_ready, div_busy}, 32'd0);
  endtask

  initial begin
    int          k, t1, t2;
    logic        bad;
    logic [1:0]  op;
    logic [31:0] a, b, r1, r2;

    rst_n = 1'b0; div_start = 1'b0; div_op = 2'b00;
    dividend = 32'd0; divisor = 32'd0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_out", {div_result[31:2], div_res_ready, div_busy}, 32'd0);
    check("reset_res", div_result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic unsigned and signed operations
    do_op(2'b01, 32'd100, 32'd7, "divu_100_7");
    do_op(2'b11, 32'd100, 32'd7, "remu_100_7");
    do_op(2'b00, 32'hFFFF_FF9C, 32'd7, "div_neg");
    do_op(2'b10, 32'hFFFF_FF9C, 32'd7, "rem_neg");
    do_op(2'b10, 32'd7, 32'hFFFF_FFFE, "rem_negdiv");
    check("div_neg_const", ref_res(2'b00, 32'hFFFF_FF9C, 32'd7), 32'hFFFF_FFF2);

    // Divide by zero and signed overflow
    do_op(2'b00, 32'd5, 32'd0, "div_by0");
    do_op(2'b01, 32'd5, 32'd0, "divu_by0");
    do_op(2'b10, 32'd5, 32'd0, "rem_by0");
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, "divu_big");

    // Flush in CALC: no ready pulse, busy drops on the next cycle
    div_op = 2'b01; dividend = 32'd1000; divisor = 32'd3; div_start = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (div_res_ready !== 1'b0) bad = 1'b1;
    end
    flush = 1'b1; div_start = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    check("flush_noready", {31'd0, bad | div_res_ready}, 32'd0);
    check("flush_busy", {31'd0, div_busy}, 32'd0);
    repeat (40) begin
      @(negedge clk);
      if (div_res_ready !== 1'b0) bad = 1'b1;
    end
    check("flush_late_ready", {31'd0, bad}, 32'd0);
    do_op(2'b01, 32'd9, 32'd3, "divu_after_flush");

    // Back-to-back with start held high: two pulses 34 cycles apart
    div_op = 2'b01; dividend = 32'd20; divisor = 32'd4; div_start = 1'b1;
    k = 0; t1 = 0; t2 = 0; r1 = 'x; r2 = 'x;
    while (t2 == 0 && k < 120) begin
      @(negedge clk);
      k++;
      if (div_res_ready === 1'b1) begin
        if (t1 == 0) begin
          t1 = k; r1 = div_result;
          dividend = 32'd23; divisor = 32'd4;
        end else begin
          t2 = k; r2 = div_result;
        end
      end
    end
    div_start = 1'b0;
    check("b2b_first_lat", 32'(t1), 32'd33);
    check("b2b_gap", 32'(t2 - t1), 32'd34);
    check("b2b_res1", r1, ref_res(2'b01, 32'd20, 32'd4));
    check("b2b_res2", r2, ref_res(2'b01, 32'd23, 32'd4));
    @(negedge clk);

    // Async reset in the middle of CALC clears everything at once
    div_op = 2'b00; dividend = 32'h1234_5678; divisor = 32'd13; div_start = 1'b1;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_flags", {30'd0, div_res_ready, div_busy}, 32'd0);
    check("rst_mid_res", div_result, 32'd0);
    div_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Random operations, biased towards the corner cases
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = 32'($urandom_range(1, 20));
        3:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
        default: ;
      endcase
      do_op(op, a, b, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
